// File: rtl/conv_pe_param.sv
`default_nettype none
// ============================================================================
// Module   : conv_pe_param
// Purpose  : Parametrised single-channel 2-D convolution processing element.
//            Streams a raster-order feature map, keeps (K-1) image lines plus
//            a KxK window in one shift chain, and emits one fixed-point MAC
//            result (bias, floor shift, optional ReLU, saturation) per valid
//            window position with a fixed two-cycle latency.
// Ports    : clk, reset_n        - clock, synchronous active-low reset
//            weight_wr/weight_in - raster-order weight loading (idle only)
//            bias_in, relu_en    - per-frame static controls
//            pix_valid/pix_in    - pixel stream, no backpressure
//            weights_ready, busy - status
//            out_valid/out_data  - result stream
//            frame_done          - pulse with the last result of a frame
// Revision : 1.0 - initial release
// ============================================================================
module conv_pe_param #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int STRIDE = 1,
    parameter int ACC_W  = 2*DATA_W+8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     weight_wr,
    input  logic signed [DATA_W-1:0] weight_in,
    input  logic signed [DATA_W-1:0] bias_in,
    input  logic                     relu_en,
    input  logic                     pix_valid,
    input  logic signed [DATA_W-1:0] pix_in,
    output logic                     weights_ready,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     frame_done
);

    localparam int c_ntap     = K*K;
    // Newest pixel sits at index 0; the window's top-left pixel is the oldest tap.
    localparam int c_sr_len   = (K-1)*IMG_W + K;
    localparam int c_cw       = (IMG_W > 1)  ? $clog2(IMG_W)  : 1;
    localparam int c_rw       = (IMG_H > 1)  ? $clog2(IMG_H)  : 1;
    localparam int c_pw       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int c_iw       = $clog2(c_ntap);
    // Position of the pixel that completes the last window of a frame.
    localparam int c_last_row = K-1 + ((IMG_H-K)/STRIDE)*STRIDE;
    localparam int c_last_col = K-1 + ((IMG_W-K)/STRIDE)*STRIDE;
    localparam logic signed [ACC_W-1:0] c_sat_max =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0]   r_wt [c_ntap];
    logic [c_iw-1:0]            r_widx;
    logic                       r_wready;
    logic [c_cw-1:0]            r_col;
    logic [c_rw-1:0]            r_row;
    logic [c_pw-1:0]            r_cph;
    logic [c_pw-1:0]            r_rph;
    logic signed [DATA_W-1:0]   r_sr [c_sr_len];
    logic                       r_v0;
    logic                       r_l0;
    logic                       r_v1;
    logic                       r_l1;
    logic signed [2*DATA_W-1:0] r_prod [c_ntap];
    logic signed [DATA_W-1:0]   r_out;
    logic                       r_out_v;
    logic                       r_done;
    logic                       r_busy;

    logic                       w_win_valid;
    logic                       w_last_pos;
    logic                       w_col_end;
    logic                       w_row_end;
    logic signed [ACC_W-1:0]    w_acc;
    logic signed [ACC_W-1:0]    w_tot;
    logic signed [ACC_W-1:0]    w_shr;
    logic signed [ACC_W-1:0]    w_act;
    logic signed [DATA_W-1:0]   w_res;

    // Phase counters are zero exactly on rows/cols that start a stride step.
    assign w_win_valid = (r_row >= c_rw'(K-1)) && (r_col >= c_cw'(K-1)) &&
                         (r_rph == '0) && (r_cph == '0);
    assign w_last_pos  = (r_row == c_rw'(c_last_row)) && (r_col == c_cw'(c_last_col));
    assign w_col_end   = (r_col == c_cw'(IMG_W-1));
    assign w_row_end   = (r_row == c_rw'(IMG_H-1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_widx   <= '0;
            r_wready <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
            r_cph    <= '0;
            r_rph    <= '0;
            r_v0     <= 1'b0;
            r_l0     <= 1'b0;
            r_v1     <= 1'b0;
            r_l1     <= 1'b0;
            r_out    <= '0;
            r_out_v  <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            for (int i = 0; i < c_ntap; i++) begin
                r_wt[i] <= '0;
            end
            for (int i = 0; i < c_sr_len; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            if (weight_wr && !r_busy) begin
                r_wt[r_widx] <= weight_in;
                if (r_widx == c_iw'(c_ntap-1)) begin
                    r_widx   <= '0;
                    r_wready <= 1'b1;
                end else begin
                    r_widx <= r_widx + c_iw'(1);
                end
            end

            if (pix_valid) begin
                r_sr[0] <= pix_in;
                for (int i = 1; i < c_sr_len; i++) begin
                    r_sr[i] <= r_sr[i-1];
                end
                if (w_col_end) begin
                    r_col <= '0;
                    r_cph <= '0;
                    if (w_row_end) begin
                        r_row <= '0;
                        r_rph <= '0;
                    end else begin
                        r_row <= r_row + c_rw'(1);
                        // Rows above K-1 keep phase 0 so row K-1 is the first hit.
                        if (r_row < c_rw'(K-1)) begin
                            r_rph <= '0;
                        end else if (r_rph == '0) begin
                            r_rph <= c_pw'(STRIDE-1);
                        end else begin
                            r_rph <= r_rph - c_pw'(1);
                        end
                    end
                end else begin
                    r_col <= r_col + c_cw'(1);
                    if (r_col < c_cw'(K-1)) begin
                        r_cph <= '0;
                    end else if (r_cph == '0) begin
                        r_cph <= c_pw'(STRIDE-1);
                    end else begin
                        r_cph <= r_cph - c_pw'(1);
                    end
                end
            end

            // Pipeline advances every cycle; only pixel intake is gated.
            r_v0    <= pix_valid && w_win_valid;
            r_l0    <= pix_valid && w_win_valid && w_last_pos;
            r_v1    <= r_v0;
            r_l1    <= r_l0;
            r_out_v <= r_v1;
            r_done  <= r_l1;
            if (r_v1) begin
                r_out <= w_res;
            end

            // Busy while a frame is partially received or results are in flight;
            // drops on the edge after frame_done when nothing else is pending.
            r_busy <= pix_valid || (r_row != '0) || (r_col != '0) || r_v0 || r_v1;
        end
    end

    // Stage 1: one registered full-width product per window tap.
    for (genvar i = 0; i < c_ntap; i++) begin : g_mac
        localparam int c_tap = (K-1-(i/K))*IMG_W + (K-1-(i%K));
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_prod[i] <= '0;
            end else if (r_v0) begin
                r_prod[i] <= (2*DATA_W)'(r_sr[c_tap]) * (2*DATA_W)'(r_wt[i]);
            end
        end
    end

    // Stage 2: sum, bias, floor shift, ReLU, saturate.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < c_ntap; i++) begin
            w_acc = w_acc + ACC_W'(r_prod[i]);
        end
        w_tot = w_acc + (ACC_W'(bias_in) <<< FRAC_W);
        w_shr = w_tot >>> FRAC_W;
        w_act = (relu_en && w_shr[ACC_W-1]) ? '0 : w_shr;
        if (w_act > c_sat_max) begin
            w_res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_act < c_sat_min) begin
            w_res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            w_res = w_act[DATA_W-1:0];
        end
    end

    assign weights_ready = r_wready;
    assign busy          = r_busy;
    assign out_valid     = r_out_v;
    assign out_data      = r_out;
    assign frame_done    = r_done;

endmodule
`default_nettype wire
